cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
Shares one external magnitude comparator between NREQ requesters. Round-robin arbitration picks a requester, latches its operand pair, and drives the comparator. After CMP_LAT cycles it samples the gt/eq/lt flags and returns them to the granted requester with a one-cycle valid pulse. Sits between requester logic in the user project and the shared comparator datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 2, operand width in bits
CMP_LAT, 1, cycles from operand drive to flag sampling (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req  in  NREQ  per-requester request; held with operands until gnt seen
a_in  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
b_in  in  NREQ*WIDTH  operand B, same packing
gnt  out  NREQ  one-hot, one-cycle pulse: request accepted, operands latched
rsp_valid  out  NREQ  one-hot, one-cycle pulse: result for requester i
rsp_gt  out  1  sampled A>B flag, valid with rsp_valid
rsp_eq  out  1  sampled A==B flag
rsp_lt  out  1  sampled A<B flag
busy  out  1  high while a compare is in flight (state WAIT)
cmp_a  out  WIDTH  operand A to shared comparator (registered)
cmp_b  out  WIDTH  operand B to shared comparator (registered)
cmp_gt  in  1  comparator A>B
cmp_eq  in  1  comparator A==B
cmp_lt  in  1  comparator A<B

Behaviour:
- Clock clk; reset rst is asynchronous, active-high. Reset state: IDLE, rr pointer 0, cnt 0, gnt 0, rsp_valid 0, rsp_gt/eq/lt 0, cmp_a/cmp_b 0, busy 0.
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE with req==0: hold state; gnt and rsp_valid remain 0.
- IDLE with any req: winner = first set req bit searching ptr, ptr+1, ..., wrapping mod NREQ. At the edge: cmp_a/cmp_b <= winner operands, id <= winner, gnt[winner] <= 1 for one cycle, cnt <= CMP_LAT-1, busy <= 1, state -> WAIT.
- WAIT with cnt>0: cnt decrements; cmp_a/cmp_b held; req ignored.
- WAIT with cnt==0: at the edge: rsp_gt/eq/lt <= cmp_gt/eq/lt, rsp_valid[id] <= 1 for one cycle, ptr <= (id+1) mod NREQ, busy <= 0, state -> IDLE.
- rsp_gt/eq/lt hold their value until the next response.
- Latency: req sampled in IDLE at edge N; gnt is high in cycle N+1; rsp_valid is high in cycle N+CMP_LAT+1. One compare per CMP_LAT+1 cycles.
- Requester contract: deassert req, or present a new operand pair, at the edge after gnt is seen. req still high when the arbiter returns to IDLE is a new request.
- req dropped before grant: no effect; never granted.
- Simultaneous requests: exactly one grant per IDLE pass; round-robin bounds wait to NREQ-1 grants.
- ptr wraps from NREQ-1 to 0.
- rst mid-WAIT: in-flight compare is aborted; no rsp_valid is issued; all outputs go to reset values immediately.
- Operands are sampled only at grant; a_in/b_in changes during WAIT do not affect the result.

Optional Feature:
CMP_SHARE_CHECK_EN
- Defined: adds output port flag_err (1 bit). It is sticky, set at the sampling edge if {cmp_gt,cmp_eq,cmp_lt} is not exactly one-hot, and cleared only by rst. The response is still returned unmodified.
- Undefined: flag_err port and its logic are absent; flags are not checked.

Test Plan:
All cases use NREQ=4, WIDTH=2, CMP_LAT=1 unless stated.
- Single request: req=0001, A0=2, B0=1 -> gnt=0001 one cycle later; rsp_valid=0001 two cycles after req sample; gt=1, eq=0, lt=0; cmp_a=2, cmp_b=1.
- Exhaustive sweep on requester 2: A=0..3 x B=0..3 (16 pairs) -> flags match A>B, A==B, A<B for every pair; rsp_valid only on bit 2.
- Round-robin: req=1111 held throughout, each requester re-asserting after its gnt -> grant order 0,1,2,3,0; no requester granted twice before all four are served.
- Reset mid-operation: assert rst in the WAIT cycle after grant to requester 1 -> no rsp_valid; gnt=0, busy=0, ptr=0; next req=0010 served normally.
- CMP_LAT=3 with operand change: A3=1, B3=1; a_in changes to 3 during WAIT -> rsp_valid 4 cycles after sample with eq=1; busy high for exactly 3 cycles.
- CMP_SHARE_CHECK_EN defined: comparator model forces gt=eq=1 on one compare -> flag_err=1 from that sampling edge; it stays 1 through later correct compares until rst.

Source files
------------

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one external magnitude comparator among NREQ requesters.
// Optional macro CMP_SHARE_CHECK_EN adds a sticky flag_err output for non-one-hot comparator flags.
module cmp_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 2,
  parameter int CMP_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic                    rsp_gt,
  output logic                    rsp_eq,
  output logic                    rsp_lt,
  output logic                    busy,
  output logic [WIDTH-1:0]        cmp_a,
  output logic [WIDTH-1:0]        cmp_b,
  input  logic                    cmp_gt,
  input  logic                    cmp_eq,
  input  logic                    cmp_lt
`ifdef CMP_SHARE_CHECK_EN
  ,
  output logic                    flag_err
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(CMP_LAT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_d, rsp_valid_d;
  logic             gt_d, eq_d, lt_d, busy_d;
  logic [WIDTH-1:0] cmp_a_d, cmp_b_d;
  logic             found;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] sel_a, sel_b;
`ifdef CMP_SHARE_CHECK_EN
  logic             err_d;
`endif

  // Rotating priority search starting at ptr; first set request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[IDW'((int'(ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        sel_a = a_in[i*WIDTH +: WIDTH];
        sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    gt_d        = rsp_gt;
    eq_d        = rsp_eq;
    lt_d        = rsp_lt;
    busy_d      = busy;
    cmp_a_d     = cmp_a;
    cmp_b_d     = cmp_b;
`ifdef CMP_SHARE_CHECK_EN
    err_d       = flag_err;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          cmp_a_d    = sel_a;
          cmp_b_d    = sel_b;
          id_d       = win;
          gnt_d[win] = 1'b1;
          cnt_d      = CW'(CMP_LAT - 1);
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          gt_d              = cmp_gt;
          eq_d              = cmp_eq;
          lt_d              = cmp_lt;
          rsp_valid_d[id_q] = 1'b1;
          ptr_d             = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          busy_d            = 1'b0;
          state_d           = IDLE;
`ifdef CMP_SHARE_CHECK_EN
          if (!$onehot({cmp_gt, cmp_eq, cmp_lt})) err_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any in-flight compare; no response is produced for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
      busy      <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
`ifdef CMP_SHARE_CHECK_EN
      flag_err  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_gt    <= gt_d;
      rsp_eq    <= eq_d;
      rsp_lt    <= lt_d;
      busy      <= busy_d;
      cmp_a     <= cmp_a_d;
      cmp_b     <= cmp_b_d;
`ifdef CMP_SHARE_CHECK_EN
      flag_err  <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: transaction-level round-robin model, CMP_LAT=1 and CMP_LAT=3 instances.
// Define CMP_SHARE_CHECK_EN to also exercise flag_err.
module tb_cmp_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 2;
  localparam int LAT3  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req, gnt, rsp_valid;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic                  rsp_gt, rsp_eq, rsp_lt, busy;
  logic [WIDTH-1:0]      cmp_a, cmp_b;
  logic                  cmp_gt, cmp_eq, cmp_lt;
  logic                  bad;

  logic [NREQ-1:0]       req3, gnt3, rsp_valid3;
  logic [NREQ*WIDTH-1:0] a3, b3;
  logic                  rsp_gt3, rsp_eq3, rsp_lt3, busy3;
  logic [WIDTH-1:0]      cmp_a3, cmp_b3;
  logic                  cmp_gt3, cmp_eq3, cmp_lt3;
`ifdef CMP_SHARE_CHECK_EN
  logic                  flag_err, flag_err3;
`endif

  // Shared comparator models; 'bad' forces an illegal gt=eq=1 pattern.
  assign cmp_gt  = bad | (cmp_a > cmp_b);
  assign cmp_eq  = bad | (cmp_a == cmp_b);
  assign cmp_lt  = !bad && (cmp_a < cmp_b);
  assign cmp_gt3 = cmp_a3 > cmp_b3;
  assign cmp_eq3 = cmp_a3 == cmp_b3;
  assign cmp_lt3 = cmp_a3 < cmp_b3;

  cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CMP_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
    .busy(busy), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt)
`ifdef CMP_SHARE_CHECK_EN
    , .flag_err(flag_err)
`endif
  );

  cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CMP_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .a_in(a3), .b_in(b3),
    .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_gt(rsp_gt3), .rsp_eq(rsp_eq3), .rsp_lt(rsp_lt3),
    .busy(busy3), .cmp_a(cmp_a3), .cmp_b(cmp_b3),
    .cmp_gt(cmp_gt3), .cmp_eq(cmp_eq3), .cmp_lt(cmp_lt3)
`ifdef CMP_SHARE_CHECK_EN
    , .flag_err(flag_err3)
`endif
  );

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  bit errModel = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester with req set, scanning from ptr upward with wrap.
  function automatic int pickWinner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] av,
                               input logic [NREQ*WIDTH-1:0] bv, input bit badv);
    @(negedge clk);
    req  = r;
    a_in = av;
    b_in = bv;
    bad  = badv;
  endtask

  // One full transaction on the CMP_LAT=1 instance: grant, response, then one idle hold cycle.
  task automatic runCompare(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] av,
                            input logic [NREQ*WIDTH-1:0] bv, input bit badv, input string tag);
    int w;
    logic [WIDTH-1:0] ea, eb;
    logic egt, eeq, elt;
    w   = pickWinner(r, mptr);
    ea  = av[w*WIDTH +: WIDTH];
    eb  = bv[w*WIDTH +: WIDTH];
    egt = badv || (ea > eb);
    eeq = badv || (ea == eb);
    elt = !badv && (ea < eb);
    applyStimulus(r, av, bv, badv);
    @(posedge clk); #1;
    checkOutput({tag, "_gnt"}, gnt, 32'(1) << w);
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_cmp_a"}, cmp_a, ea);
    checkOutput({tag, "_cmp_b"}, cmp_b, eb);
    checkOutput({tag, "_early_rsp"}, rsp_valid, 0);
    @(negedge clk);
    req  = r & ~(4'b0001 << w);
    a_in = ~av;
    @(posedge clk); #1;
    errModel = errModel | badv;
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 32'(1) << w);
    checkOutput({tag, "_flags"}, {rsp_gt, rsp_eq, rsp_lt}, {egt, eeq, elt});
    checkOutput({tag, "_gnt_low"}, gnt, 0);
    checkOutput({tag, "_busy_low"}, busy, 0);
`ifdef CMP_SHARE_CHECK_EN
    checkOutput({tag, "_flag_err"}, flag_err, errModel);
`endif
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    checkOutput({tag, "_hold_valid"}, rsp_valid, 0);
    checkOutput({tag, "_hold_flags"}, {rsp_gt, rsp_eq, rsp_lt}, {egt, eeq, elt});
    mptr = (w + 1) % NREQ;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr     = 0;
    errModel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NREQ*WIDTH-1:0] av, bv;
    int busyCycles, rspAt;
    logic [NREQ-1:0] rspSeen;
    logic eqSeen;
    logic [WIDTH-1:0] heldA;

    rst = 1'b0; req = '0; a_in = '0; b_in = '0; bad = 1'b0;
    req3 = '0; a3 = '0; b3 = '0;
    #2 rst = 1'b1;
    #2;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_flags", {rsp_gt, rsp_eq, rsp_lt}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cmp", {cmp_a, cmp_b}, 0);
`ifdef CMP_SHARE_CHECK_EN
    checkOutput("rst_flag_err", flag_err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single request on requester 0: A0=2, B0=1.
    runCompare(4'b0001, 8'h02, 8'h01, 1'b0, "single");

    // Exhaustive operand sweep on requester 2 with random noise in other lanes.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        av[5:4] = 2'(a);
        bv[5:4] = 2'(b);
        runCompare(4'b0100, av, bv, 1'b0, "sweep");
      end
    end

    // Round-robin from a known pointer with all four requesting.
    resetPulse();
    for (int i = 0; i < 5; i++) begin
      runCompare(4'b1111, 8'($urandom), 8'($urandom), 1'b0, "rr");
    end

    // Reset mid-WAIT after grant to requester 1 (pointer moved to 3 first).
    runCompare(4'b0100, 8'h30, 8'h00, 1'b0, "pre_rst");
    applyStimulus(4'b0010, 8'h08, 8'h04, 1'b0);
    @(posedge clk); #1;
    checkOutput("midrst_gnt", gnt, 4'b0010);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_gnt_clr", gnt, 0);
    checkOutput("midrst_busy_clr", busy, 0);
    checkOutput("midrst_flags_clr", {rsp_gt, rsp_eq, rsp_lt}, 0);
    checkOutput("midrst_cmp_clr", {cmp_a, cmp_b}, 0);
    @(posedge clk); #1;
    checkOutput("midrst_no_rsp", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    errModel = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_no_rsp_after", rsp_valid, 0);
    runCompare(4'b1111, 8'($urandom), 8'($urandom), 1'b0, "post_rst_ptr");
    runCompare(4'b0010, 8'h04, 8'h0C, 1'b0, "post_rst");

    // Randomized traffic against the round-robin model.
    for (int i = 0; i < 24; i++) begin
      runCompare(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 1'b0, "rand");
    end

`ifdef CMP_SHARE_CHECK_EN
    // Illegal comparator flags set flag_err, which stays set until reset.
    runCompare(4'b0001, 8'h00, 8'h03, 1'b1, "fault");
    runCompare(4'b1000, 8'h40, 8'h80, 1'b0, "after_fault");
    checkOutput("err_sticky", flag_err, 1);
    resetPulse();
    checkOutput("err_cleared", flag_err, 0);
`endif

    // CMP_LAT=3 instance: operand change during WAIT must not matter.
    @(negedge clk);
    req3 = 4'b1000;
    a3 = 8'h40;
    b3 = 8'h40;
    @(posedge clk); #1;
    checkOutput("lat3_gnt", gnt3, 4'b1000);
    checkOutput("lat3_busy", busy3, 1);
    @(negedge clk);
    req3 = '0;
    a3 = 8'hC0;
    busyCycles = 1;
    rspAt = -1;
    rspSeen = '0;
    eqSeen = 1'b0;
    heldA = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) heldA = cmp_a3;
      if (busy3) busyCycles++;
      if (rsp_valid3 != '0 && rspAt < 0) begin
        rspAt = c;
        rspSeen = rsp_valid3;
        eqSeen = rsp_eq3;
      end
    end
    checkOutput("lat3_cmp_a_held", heldA, 1);
    checkOutput("lat3_rsp_edge", rspAt, LAT3);
    checkOutput("lat3_busy_cycles", busyCycles, LAT3);
    checkOutput("lat3_rsp_valid", rspSeen, 4'b1000);
    checkOutput("lat3_eq", eqSeen, 1);
`ifdef CMP_SHARE_CHECK_EN
    checkOutput("lat3_flag_err", flag_err3, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
